led_scan_ctrl: RTL

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

---
 rtl/led_scan_ctrl_if.sv | 28 ++
 rtl/led_scan_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl_if.sv
// rtl/led_scan_ctrl_if.sv - back-buffer write and buffer-swap handshake bundle
//
// Signals:
//   wr_en        back-buffer write strobe
//   wr_addr      LED index, row = wr_addr[3:2], col = wr_addr[1:0]
//   wr_data      brightness 0 (off) .. 15 (full)
//   swap_req     request front/back exchange at the next frame boundary
//   swap_pending high from the cycle after an accepted swap_req until the swap
//   swap_ack     one-cycle pulse in the cycle the swap executes
// Modports: master drives writes/requests, slave is the scan controller.
interface led_scan_ctrl_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       swap_req;
    logic       swap_pending;
    logic       swap_ack;

    modport master (
        output wr_en, wr_addr, wr_data, swap_req,
        input  swap_pending, swap_ack
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, swap_req,
        output swap_pending, swap_ack
    );
endinterface

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - double-buffered 4x4 LED matrix scanner with 15-step PWM
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          led_scan_ctrl_if.slave: back-buffer writes and swap handshake
//   frame_start  one-cycle pulse on the tick where row wraps 3 -> 0
//   aled         registered one-hot row (anode) select, 0 during blanking
//   kled_tri     registered column (cathode) enables, 1 lights the LED
// Parameters:
//   PRESCALE     clk cycles per scan tick (1..65535)
//   BLANK_TICKS  all-off ticks before each row (1..15)
module led_scan_ctrl #(
    parameter int PRESCALE    = 188,
    parameter int BLANK_TICKS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    led_scan_ctrl_if.slave    bus,
    output logic              frame_start,
    output logic [3:0]        aled,
    output logic [3:0]        kled_tri
);

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    localparam logic [15:0] PRE_LAST   = 16'(PRESCALE - 1);
    localparam logic [3:0]  BLANK_LAST = 4'(BLANK_TICKS - 1);
    localparam logic [3:0]  PWM_LAST   = 4'd14;

    state_t            state, state_nxt;
    logic [15:0]       pre_cnt;
    logic              tick;
    logic [3:0]        blank_cnt;
    logic [3:0]        pwm_cnt;
    logic [1:0]        row;
    logic              front_sel;      // 0: buffer A is front, 1: buffer B is front
    logic [15:0][3:0]  buf_a;
    logic [15:0][3:0]  buf_b;
    logic [3:0][3:0]   lat;            // current row's brightness, frozen for the ON period
    logic              swap_pending_q;

    logic              blank_done;
    logic              on_done;
    logic              boundary;
    logic              swap_exec;
    logic [3:0][3:0]   front_row;
    logic [3:0]        kled_first;
    logic [3:0]        kled_next;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        blank_done = 1'b0;
        on_done    = 1'b0;
        case (state)
            ST_BLANK: begin
                if (tick && blank_cnt == BLANK_LAST) begin
                    state_nxt  = ST_ON;
                    blank_done = 1'b1;
                end
            end
            ST_ON: begin
                if (tick && pwm_cnt == PWM_LAST) begin
                    state_nxt = ST_BLANK;
                    on_done   = 1'b1;
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    // Frame boundary is the last ON tick of row 3; a swap only happens if it was
    // already pending, so a request landing on the boundary waits a full frame.
    assign boundary  = on_done && (row == 2'd3);
    assign swap_exec = boundary && swap_pending_q;

    always_comb begin
        front_row  = '0;
        kled_first = '0;
        kled_next  = '0;
        for (int c = 0; c < 4; c++) begin
            front_row[c]  = front_sel ? buf_b[{row, 2'(c)}] : buf_a[{row, 2'(c)}];
            kled_first[c] = (front_row[c] != 4'd0);
            kled_next[c]  = ((pwm_cnt + 4'd1) < lat[c]);
        end
    end

    // Outputs are registered alongside the state change, so aled/kled_tri
    // line up with the state they belong to rather than trailing by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt        <= '0;
            blank_cnt      <= '0;
            pwm_cnt        <= '0;
            row            <= '0;
            front_sel      <= 1'b0;
            buf_a          <= '0;
            buf_b          <= '0;
            lat            <= '0;
            swap_pending_q <= 1'b0;
            aled           <= '0;
            kled_tri       <= '0;
        end else begin
            pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;

            if (tick) begin
                if (state == ST_BLANK) begin
                    if (blank_done) begin
                        blank_cnt <= '0;
                        pwm_cnt   <= '0;
                        lat       <= front_row;
                        aled      <= 4'b0001 << row;
                        kled_tri  <= kled_first;
                    end else begin
                        blank_cnt <= blank_cnt + 4'd1;
                    end
                end else begin
                    if (on_done) begin
                        row      <= row + 2'd1;
                        aled     <= '0;
                        kled_tri <= '0;
                    end else begin
                        pwm_cnt  <= pwm_cnt + 4'd1;
                        kled_tri <= kled_next;
                    end
                end
            end

            // Write uses the pre-swap back buffer even when a swap fires this cycle.
            if (bus.wr_en) begin
                if (front_sel) begin
                    buf_a[bus.wr_addr] <= bus.wr_data;
                end else begin
                    buf_b[bus.wr_addr] <= bus.wr_data;
                end
            end

            if (swap_exec) begin
                front_sel <= ~front_sel;
            end

            // A request during the ack cycle is absorbed by the swap in progress.
            swap_pending_q <= swap_exec ? 1'b0 : (swap_pending_q | bus.swap_req);
        end
    end

    assign frame_start      = boundary;
    assign bus.swap_ack     = swap_exec;
    assign bus.swap_pending = swap_pending_q;

endmodule
